// File: rtl/pu_local_ctrl.sv
// rtl/pu_local_ctrl.sv - Local sequencer for the processing unit (read, accumulate, write per output)
//
// Purpose:
//   On an accepted i_prcss_start the controller latches the job configuration and
//   walks all M output elements. Each output takes K read beats on the x/w buffers,
//   PE_LAT wait cycles for the PE pipeline, and one y buffer write of i_pe_acc.
//   Per-output latency is K + PE_LAT + 1 cycles. A one-cycle DONE state pulses
//   o_prcss_done and sets the o_all_done level.
//
// Ports:
//   i_clk, i_rst              clock, synchronous active-high reset
//   i_prcss_start             job start pulse (accepted only in IDLE)
//   i_cfg_num_out             M, outputs per job
//   i_cfg_k_steps             K, read beats per output
//   i_cfg_y_base              first y buffer address
//   o_x_buf_en/o_x_buf_addr   x buffer read port (address = k)
//   o_w_buf_en/o_w_buf_addr   w buffer read port (address = m*K + k, truncated)
//   o_pe_en/o_pe_clr          PE strobes, aligned with 1-cycle buffer read data
//   i_pe_acc                  PE accumulated result
//   o_y_buf_*                 y buffer write port (address = y_base + m, data = i_pe_acc)
//   o_busy                    high outside IDLE
//   o_prcss_done              one-cycle job-end pulse
//   o_all_done                job-end level, cleared by the next accepted start

module pu_local_ctrl #(
    parameter int X_BUF_ADDR_WIDTH   = 16,
    parameter int W_BUF_ADDR_WIDTH   = 16,
    parameter int OUT_BUF_ADDR_WIDTH = 32,
    parameter int OUT_BUF_DATA_WIDTH = 32,
    parameter int CNT_WIDTH          = 16,
    parameter int PE_LAT             = 2
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_prcss_start,
    input  logic [CNT_WIDTH-1:0]          i_cfg_num_out,
    input  logic [CNT_WIDTH-1:0]          i_cfg_k_steps,
    input  logic [OUT_BUF_ADDR_WIDTH-1:0] i_cfg_y_base,
    output logic                          o_x_buf_en,
    output logic [X_BUF_ADDR_WIDTH-1:0]   o_x_buf_addr,
    output logic                          o_w_buf_en,
    output logic [W_BUF_ADDR_WIDTH-1:0]   o_w_buf_addr,
    output logic                          o_pe_en,
    output logic                          o_pe_clr,
    input  logic [OUT_BUF_DATA_WIDTH-1:0] i_pe_acc,
    output logic                          o_y_buf_en,
    output logic                          o_y_buf_wr_en,
    output logic [OUT_BUF_ADDR_WIDTH-1:0] o_y_buf_addr,
    output logic [OUT_BUF_DATA_WIDTH-1:0] o_y_buf_data,
    output logic                          o_busy,
    output logic                          o_prcss_done,
    output logic                          o_all_done
);

    localparam int LAT_W  = $clog2(PE_LAT + 1);
    localparam int PROD_W = 2 * CNT_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_WAIT  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                        r_state;
    state_t                        w_next;

    logic [CNT_WIDTH-1:0]          r_num_out;
    logic [CNT_WIDTH-1:0]          r_k_steps;
    logic [OUT_BUF_ADDR_WIDTH-1:0] r_y_base;
    logic [CNT_WIDTH-1:0]          r_m;
    logic [CNT_WIDTH-1:0]          r_k;
    logic [LAT_W-1:0]              r_lat;
    logic                          r_pe_en;
    logic                          r_pe_clr;
    logic                          r_all_done;

    logic                          w_cfg_zero;
    logic                          w_k_last;
    logic                          w_m_last;
    logic                          w_lat_last;
    logic                          w_read;
    logic                          w_write;
    logic [PROD_W-1:0]             w_w_addr_full;

    // A zero-sized job spends its first busy cycle in READ, where the latched
    // configuration is evaluated; the read strobes are suppressed and the FSM
    // moves straight on to DONE.
    assign w_cfg_zero = (r_num_out == '0) || (r_k_steps == '0);
    assign w_k_last   = (r_k == r_k_steps - CNT_WIDTH'(1));
    assign w_m_last   = (r_m == r_num_out - CNT_WIDTH'(1));
    assign w_lat_last = (r_lat == LAT_W'(PE_LAT - 1));
    assign w_read     = (r_state == S_READ) && !w_cfg_zero;
    assign w_write    = (r_state == S_WRITE);

    // w address is formed at double counter width and then truncated, so
    // overflow wraps rather than saturating.
    assign w_w_addr_full = PROD_W'(r_m) * PROD_W'(r_k_steps) + PROD_W'(r_k);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_prcss_start) begin
                    w_next = S_READ;
                end
            end
            S_READ: begin
                if (w_cfg_zero) begin
                    w_next = S_DONE;
                end else if (w_k_last) begin
                    w_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (w_lat_last) begin
                    w_next = S_WRITE;
                end
            end
            S_WRITE: begin
                if (w_m_last) begin
                    w_next = S_DONE;
                end else begin
                    w_next = S_READ;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_num_out  <= '0;
            r_k_steps  <= '0;
            r_y_base   <= '0;
            r_m        <= '0;
            r_k        <= '0;
            r_lat      <= '0;
            r_pe_en    <= 1'b0;
            r_pe_clr   <= 1'b0;
            r_all_done <= 1'b0;
        end else begin
            r_state  <= w_next;
            // Buffer data returns one cycle after the read, so the PE strobes
            // are the read strobes delayed by one register.
            r_pe_en  <= w_read;
            r_pe_clr <= w_read && (r_k == '0);
            case (r_state)
                S_IDLE: begin
                    if (i_prcss_start) begin
                        r_num_out  <= i_cfg_num_out;
                        r_k_steps  <= i_cfg_k_steps;
                        r_y_base   <= i_cfg_y_base;
                        r_m        <= '0;
                        r_k        <= '0;
                        r_lat      <= '0;
                        r_all_done <= 1'b0;
                    end
                end
                S_READ: begin
                    if (!w_cfg_zero) begin
                        if (w_k_last) begin
                            r_k <= '0;
                        end else begin
                            r_k <= r_k + CNT_WIDTH'(1);
                        end
                    end
                end
                S_WAIT: begin
                    if (w_lat_last) begin
                        r_lat <= '0;
                    end else begin
                        r_lat <= r_lat + LAT_W'(1);
                    end
                end
                S_WRITE: begin
                    if (!w_m_last) begin
                        r_m <= r_m + CNT_WIDTH'(1);
                    end
                end
                S_DONE: begin
                    r_all_done <= 1'b1;
                end
                default: begin
                    r_k <= '0;
                end
            endcase
        end
    end

    assign o_x_buf_en    = w_read;
    assign o_x_buf_addr  = w_read ? X_BUF_ADDR_WIDTH'(r_k) : '0;
    assign o_w_buf_en    = w_read;
    assign o_w_buf_addr  = w_read ? w_w_addr_full[W_BUF_ADDR_WIDTH-1:0] : '0;
    assign o_pe_en       = r_pe_en;
    assign o_pe_clr      = r_pe_clr;
    assign o_y_buf_en    = w_write;
    assign o_y_buf_wr_en = w_write;
    assign o_y_buf_addr  = w_write ? (r_y_base + OUT_BUF_ADDR_WIDTH'(r_m)) : '0;
    assign o_y_buf_data  = w_write ? i_pe_acc : '0;
    assign o_busy        = (r_state != S_IDLE);
    assign o_prcss_done  = (r_state == S_DONE);
    assign o_all_done    = r_all_done;

endmodule

// File: tb/tb_pu_local_ctrl.sv
// tb/tb_pu_local_ctrl.sv - Self-checking bench for pu_local_ctrl
module tb_pu_local_ctrl;

    localparam int PE_LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        prcss_start;
    logic [15:0] cfg_num_out;
    logic [15:0] cfg_k_steps;
    logic [31:0] cfg_y_base;
    logic        x_buf_en;
    logic [15:0] x_buf_addr;
    logic        w_buf_en;
    logic [15:0] w_buf_addr;
    logic        pe_en;
    logic        pe_clr;
    logic [31:0] pe_acc;
    logic        y_buf_en;
    logic        y_buf_wr_en;
    logic [31:0] y_buf_addr;
    logic [31:0] y_buf_data;
    logic        busy;
    logic        prcss_done;
    logic        all_done;

    int checks = 0;
    int errors = 0;
    logic model_ad = 1'b0;

    pu_local_ctrl #(
        .X_BUF_ADDR_WIDTH(16), .W_BUF_ADDR_WIDTH(16), .OUT_BUF_ADDR_WIDTH(32),
        .OUT_BUF_DATA_WIDTH(32), .CNT_WIDTH(16), .PE_LAT(PE_LAT)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_prcss_start(prcss_start),
        .i_cfg_num_out(cfg_num_out), .i_cfg_k_steps(cfg_k_steps), .i_cfg_y_base(cfg_y_base),
        .o_x_buf_en(x_buf_en), .o_x_buf_addr(x_buf_addr),
        .o_w_buf_en(w_buf_en), .o_w_buf_addr(w_buf_addr),
        .o_pe_en(pe_en), .o_pe_clr(pe_clr), .i_pe_acc(pe_acc),
        .o_y_buf_en(y_buf_en), .o_y_buf_wr_en(y_buf_wr_en),
        .o_y_buf_addr(y_buf_addr), .o_y_buf_data(y_buf_data),
        .o_busy(busy), .o_prcss_done(prcss_done), .o_all_done(all_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          m;
        int          k;
        logic [31:0] base;
        int          inj;
        int          rst_c;
        int          exp_done;
        int          exp_nwr;
        logic [31:0] exp_last;
    } vec_t;

    vec_t tbl[10];

    function automatic logic [104:0] act_vec();
        return {busy, prcss_done, all_done, x_buf_en, x_buf_addr, w_buf_en, w_buf_addr,
                pe_en, pe_clr, y_buf_en, y_buf_wr_en, y_buf_addr, y_buf_data};
    endfunction

    // Expected outputs at cycle c of a job (start sampled at cycle 0), derived
    // from the job timeline: output m occupies cycles 1+m*P .. m*P+P, reads in
    // its first K cycles, write in its last cycle.
    function automatic logic [104:0] exp_vec(int c, int M, int K, logic [31:0] base,
                                             logic [31:0] acc, logic prev_ad);
        logic        bz, dn, ad, xe, we, pe, cl, ye;
        logic [15:0] xa, wa;
        logic [31:0] ya, yd;
        int          p, t, j, m, r;
        bit          zero;
        bz = 0; dn = 0; ad = 0; xe = 0; we = 0; pe = 0; cl = 0; ye = 0;
        xa = '0; wa = '0; ya = '0; yd = '0;
        zero = (M == 0) || (K == 0);
        p = K + PE_LAT + 1;
        t = zero ? 2 : 1 + M * p;
        if (c == 0) begin
            ad = prev_ad;
        end else if (c < t) begin
            bz = 1;
            if (!zero) begin
                j = c - 1; m = j / p; r = j % p;
                if (r < K) begin
                    xe = 1; we = 1; xa = 16'(r); wa = 16'(m * K + r);
                end
                if (r >= 1 && r <= K) pe = 1;
                if (r == 1) cl = 1;
                if (r == p - 1) begin
                    ye = 1; ya = base + 32'(m); yd = acc;
                end
            end
        end else if (c == t) begin
            bz = 1; dn = 1;
        end else begin
            ad = 1;
        end
        return {bz, dn, ad, xe, xa, we, wa, pe, cl, ye, ye, ya, yd};
    endfunction

    task automatic chk(input string name, input logic [104:0] act, input logic [104:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    // Runs one job from IDLE; inj_c >= 1 re-pulses start with junk config,
    // rst_c >= 0 pulses reset in that cycle. Returns observed done cycle,
    // write count and last write address.
    task automatic run_job(input int M, input int K, input logic [31:0] base,
                           input int inj_c, input int rst_c,
                           output int done_c, output int nwr, output logic [31:0] last_a);
        int          t, len;
        logic [104:0] ev;
        t = (M == 0 || K == 0) ? 2 : 1 + M * (K + PE_LAT + 1);
        len = t + 3;
        done_c = -1; nwr = 0; last_a = '0;
        cfg_num_out = 16'(M); cfg_k_steps = 16'(K); cfg_y_base = base;
        prcss_start = 1'b1;
        for (int c = 0; c < len; c++) begin
            pe_acc = $urandom;
            if (c > 0) begin
                prcss_start = (c == inj_c);
                if (c == inj_c) begin
                    cfg_num_out = 16'($urandom_range(1, 9));
                    cfg_k_steps = 16'($urandom_range(1, 9));
                    cfg_y_base  = $urandom;
                end
            end
            rst = (c == rst_c);
            @(negedge clk);
            if (rst_c >= 0 && c > rst_c) ev = '0;
            else ev = exp_vec(c, M, K, base, pe_acc, model_ad);
            chk($sformatf("job M=%0d K=%0d cyc=%0d", M, K, c), act_vec(), ev);
            if (y_buf_en && y_buf_wr_en) begin
                nwr++;
                last_a = y_buf_addr;
            end
            if (prcss_done) done_c = c;
            @(posedge clk);
            #1;
        end
        prcss_start = 1'b0;
        rst = 1'b0;
        model_ad = (rst_c >= 0) ? 1'b0 : 1'b1;
    endtask

    initial begin
        int          dc, nw, M, K, t, inj, edone, enwr;
        logic [31:0] la, base, elast;
        bit          zero;

        tbl[0] = '{2, 3, 32'h10,       -1, -1, 13, 2, 32'h11};
        tbl[1] = '{0, 5, 32'h80,       -1, -1,  2, 0, 32'h0};
        tbl[2] = '{3, 0, 32'h80,       -1, -1,  2, 0, 32'h0};
        tbl[3] = '{2, 3, 32'h40,        2, -1, 13, 2, 32'h41};
        tbl[4] = '{2, 3, 32'h40,       13, -1, 13, 2, 32'h41};
        tbl[5] = '{2, 3, 32'h10,       -1, 10, -1, 1, 32'h10};
        tbl[6] = '{2, 3, 32'h20,       -1, -1, 13, 2, 32'h21};
        tbl[7] = '{1, 4, 32'hFFFFFFFF, -1, -1,  8, 1, 32'hFFFFFFFF};
        tbl[8] = '{2, 4, 32'hFFFFFFFF, -1, -1, 15, 2, 32'h0};
        tbl[9] = '{1, 1, 32'h0,        -1, -1,  5, 1, 32'h0};

        rst = 1'b1; prcss_start = 1'b0; cfg_num_out = '0; cfg_k_steps = '0;
        cfg_y_base = '0; pe_acc = 32'hDEADBEEF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_state", act_vec(), '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("idle_after_reset", act_vec(), '0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 10; i++) begin
            run_job(tbl[i].m, tbl[i].k, tbl[i].base, tbl[i].inj, tbl[i].rst_c, dc, nw, la);
            chk($sformatf("tbl%0d done_cycle", i), 105'(dc), 105'(tbl[i].exp_done));
            chk($sformatf("tbl%0d write_count", i), 105'(nw), 105'(tbl[i].exp_nwr));
            chk($sformatf("tbl%0d last_y_addr", i), 105'(la), 105'(tbl[i].exp_last));
        end

        for (int i = 0; i < 40; i++) begin
            M = $urandom_range(0, 4);
            K = $urandom_range(0, 5);
            base = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFE : $urandom;
            zero = (M == 0) || (K == 0);
            t = zero ? 2 : 1 + M * (K + PE_LAT + 1);
            inj = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, t)) : -1;
            run_job(M, K, base, inj, -1, dc, nw, la);
            edone = t;
            enwr  = zero ? 0 : M;
            elast = zero ? 32'h0 : base + 32'(M - 1);
            chk($sformatf("rnd%0d done_cycle", i), 105'(dc), 105'(edone));
            chk($sformatf("rnd%0d write_count", i), 105'(nw), 105'(enwr));
            chk($sformatf("rnd%0d last_y_addr", i), 105'(la), 105'(elast));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
